// File: rtl/pipelined_adder_slice.sv
// ---------------------------------------------------------------------------
// adder_slice
//   Purely combinational CHUNK-bit adder used as one carry-pipeline stage of
//   pipelined_adder. All registers live in the parent.
//
// Ports:
//   x, y  [CHUNK-1:0]  chunk operands
//   ci                 carry into the chunk
//   s     [CHUNK-1:0]  chunk sum
//   co                 carry out of the chunk's top bit
// ---------------------------------------------------------------------------
module adder_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    // Widen by one bit so the carry falls out of the top of the sum.
    assign {co, s} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};

endmodule

// File: rtl/pipelined_adder.sv
// ---------------------------------------------------------------------------
// pipelined_adder
//   WIDTH-bit adder/subtractor split into STAGES equal chunks. Stage i adds
//   chunk i and registers its carry for stage i+1. Operands for the higher
//   chunks travel down the pipe beside the carry (skew), and finished low
//   chunks travel down beside them (de-skew), so one complete result per
//   enabled cycle is in flight. Latency is STAGES enabled cycles.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears all state regardless of ce
//   ce         clock enable; 0 freezes every register
//   in_valid   operands valid this cycle
//   sub        0 = a + b + cin, 1 = a - b - cin
//   a, b       WIDTH-bit operands
//   cin        carry-in (add) / borrow-in (subtract)
//   out_valid  registered result valid
//   sum        registered WIDTH-bit result
//   cout       carry out of bit WIDTH-1 (subtract: 1 = no borrow)
//   overflow   two's-complement overflow of the result
// ---------------------------------------------------------------------------
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             in_valid,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CHUNK = WIDTH / STAGES;
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_params
        $error("pipelined_adder: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    // Subtraction is a + ~b + 1; the borrow-in flips the injected carry.
    logic [WIDTH-1:0] bx;
    logic             c0;

    assign bx = b ^ {WIDTH{sub}};
    assign c0 = cin ^ sub;

    // Per-stage pipeline registers. Element i is written by stage i.
    logic             v_r [STAGES];   // slot valid tag
    logic             c_r [STAGES];   // carry out of chunk i
    logic [WIDTH-1:0] a_r [STAGES];   // skewed operand a
    logic [WIDTH-1:0] b_r [STAGES];   // skewed operand bx
    logic [WIDTH-1:0] s_r [STAGES];   // partial sum, chunks 0..i complete
    logic             ovf_r;

    // Per-stage inputs: stage 0 sees the ports, stage i sees register i-1.
    logic             op_v [STAGES];
    logic             op_c [STAGES];
    logic [WIDTH-1:0] op_a [STAGES];
    logic [WIDTH-1:0] op_b [STAGES];
    logic [WIDTH-1:0] op_s [STAGES];

    logic [CHUNK-1:0] sl_s   [STAGES];
    logic             sl_co  [STAGES];
    logic [WIDTH-1:0] sl_ext [STAGES];
    logic [WIDTH-1:0] nxt_s  [STAGES];
    logic             ovf_nxt;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        if (i == 0) begin : g_first
            assign op_v[i] = in_valid;
            assign op_c[i] = c0;
            assign op_a[i] = a;
            assign op_b[i] = bx;
            assign op_s[i] = '0;
        end else begin : g_next
            assign op_v[i] = v_r[i-1];
            assign op_c[i] = c_r[i-1];
            assign op_a[i] = a_r[i-1];
            assign op_b[i] = b_r[i-1];
            assign op_s[i] = s_r[i-1];
        end

        adder_slice #(
            .CHUNK (CHUNK)
        ) u_slice (
            .x  (op_a[i][i*CHUNK +: CHUNK]),
            .y  (op_b[i][i*CHUNK +: CHUNK]),
            .ci (op_c[i]),
            .s  (sl_s[i]),
            .co (sl_co[i])
        );

        // Drop this stage's chunk into its place in the travelling sum.
        assign sl_ext[i] = WIDTH'(sl_s[i]);
        assign nxt_s[i]  = (op_s[i] & ~(CHUNK_MASK << (i*CHUNK)))
                         | (sl_ext[i] << (i*CHUNK));
    end

    // The last stage produces the sign bit of the result, so overflow is
    // resolved there from the delayed operand sign bits.
    assign ovf_nxt = (op_a[STAGES-1][WIDTH-1] == op_b[STAGES-1][WIDTH-1])
                  && (sl_s[STAGES-1][CHUNK-1] != op_a[STAGES-1][WIDTH-1]);

    // NOTE: every register here uses <= so all stages shift together on one
    // edge; a blocking write would let stage i see stage i-1's new value.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: data registers are cleared too, not just valid bits, so
            // sum/cout/overflow read 0 straight after reset.
            for (int i = 0; i < STAGES; i++) begin
                v_r[i] <= 1'b0;
                c_r[i] <= 1'b0;
                a_r[i] <= '0;
                b_r[i] <= '0;
                s_r[i] <= '0;
            end
            ovf_r <= 1'b0;
        end else if (ce) begin
            for (int i = 0; i < STAGES; i++) begin
                v_r[i] <= op_v[i];
                c_r[i] <= sl_co[i];
                a_r[i] <= op_a[i];
                b_r[i] <= op_b[i];
                s_r[i] <= nxt_s[i];
            end
            ovf_r <= ovf_nxt;
        end
    end

    assign out_valid = v_r[STAGES-1];
    assign sum       = s_r[STAGES-1];
    assign cout      = c_r[STAGES-1];
    assign overflow  = ovf_r;

endmodule

// File: tb/tb_pipelined_adder.sv
// ---------------------------------------------------------------------------
// tb_pipelined_adder
//   Drives three pipelined_adder instances (STAGES = 4, 1, 16) from one
//   stimulus stream. Each captured operand set is turned into an expected
//   result by plain integer arithmetic and queued with the enabled-cycle
//   number it entered on; a monitor pops each queue when that result is due
//   and compares valid, sum, cout, overflow and timing.
// ---------------------------------------------------------------------------
module tb_pipelined_adder;

    localparam int W = 16;
    localparam int NDUT = 3;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        int           issue;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         ce = 1'b1;
    logic         in_valid = 1'b1;
    logic         sub = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;

    logic         ov [NDUT];
    logic [W-1:0] sm [NDUT];
    logic         co [NDUT];
    logic         of [NDUT];

    int    lat [NDUT] = '{4, 1, 16};
    string nm  [NDUT] = '{"s4", "s1", "s16"};

    exp_t  q [NDUT][$];
    logic  last_v [NDUT];
    exp_t  last_e [NDUT];

    int   checks = 0;
    int   failures = 0;
    int   ce_cnt = 0;
    logic adv = 1'b0;
    logic rst_seen = 1'b0;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(W), .STAGES(4)) dut4 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .sub(sub),
        .a(a), .b(b), .cin(cin),
        .out_valid(ov[0]), .sum(sm[0]), .cout(co[0]), .overflow(of[0])
    );

    pipelined_adder #(.WIDTH(W), .STAGES(1)) dut1 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .sub(sub),
        .a(a), .b(b), .cin(cin),
        .out_valid(ov[1]), .sum(sm[1]), .cout(co[1]), .overflow(of[1])
    );

    pipelined_adder #(.WIDTH(W), .STAGES(16)) dut16 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .sub(sub),
        .a(a), .b(b), .cin(cin),
        .out_valid(ov[2]), .sum(sm[2]), .cout(co[2]), .overflow(of[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    // Reference: whole-word integer arithmetic on the effective operands.
    function automatic exp_t model(input logic s, input logic [W-1:0] aa,
                                   input logic [W-1:0] bb, input logic c,
                                   input int issue);
        exp_t         e;
        logic [W-1:0] bx;
        logic         c0;
        int           full;
        int           sr;
        bx   = s ? ~bb : bb;
        c0   = c ^ s;
        full = int'(aa) + int'(bx) + int'(c0);
        sr   = int'($signed(aa)) + int'($signed(bx)) + int'(c0);
        e.s     = full[W-1:0];
        e.c     = full[W];
        e.o     = (sr > 32767) || (sr < -32768);
        e.issue = issue;
        return e;
    endfunction

    // Capture side of the scoreboard: what the DUT samples on this edge.
    always @(posedge clk) begin
        rst_seen <= reset;
        adv      <= ce && !reset;
        if (ce && !reset) ce_cnt <= ce_cnt + 1;
        if (reset) begin
            for (int k = 0; k < NDUT; k++) q[k].delete();
        end else if (ce && in_valid) begin
            for (int k = 0; k < NDUT; k++) q[k].push_back(model(sub, a, b, cin, ce_cnt + 1));
        end
    end

    task automatic mon(input int k);
        logic exp_valid;
        exp_t e;
        if (rst_seen) begin
            check({nm[k], "_rst_valid"}, 32'(ov[k]), 32'd0);
            check({nm[k], "_rst_sum"},   32'(sm[k]), 32'd0);
            check({nm[k], "_rst_cout"},  32'(co[k]), 32'd0);
            check({nm[k], "_rst_ovf"},   32'(of[k]), 32'd0);
            last_v[k] = 1'b0;
        end else if (adv) begin
            exp_valid = (q[k].size() > 0) && ((ce_cnt - q[k][0].issue) >= (lat[k] - 1));
            check({nm[k], "_valid"}, 32'(ov[k]), 32'(exp_valid));
            if (exp_valid) begin
                e = q[k].pop_front();
                check({nm[k], "_sum"},     32'(sm[k]), 32'(e.s));
                check({nm[k], "_cout"},    32'(co[k]), 32'(e.c));
                check({nm[k], "_ovf"},     32'(of[k]), 32'(e.o));
                check({nm[k], "_latency"}, 32'(ce_cnt - e.issue + 1), 32'(lat[k]));
                last_e[k] = e;
            end
            last_v[k] = exp_valid;
        end else begin
            check({nm[k], "_hold_valid"}, 32'(ov[k]), 32'(last_v[k]));
            if (last_v[k]) begin
                check({nm[k], "_hold_sum"},  32'(sm[k]), 32'(last_e[k].s));
                check({nm[k], "_hold_cout"}, 32'(co[k]), 32'(last_e[k].c));
                check({nm[k], "_hold_ovf"},  32'(of[k]), 32'(last_e[k].o));
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < NDUT; k++) mon(k);
    end

    task automatic drive(input logic v, input logic s, input logic [W-1:0] aa,
                         input logic [W-1:0] bb, input logic c,
                         input logic e, input logic r);
        @(negedge clk);
        in_valid = v;
        sub      = s;
        a        = aa;
        b        = bb;
        cin      = c;
        ce       = e;
        reset    = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'hDEAD, 16'hBEEF, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        // Reset held with live inputs.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 16'h1234, 16'h4321, 1'b1, 1'b1, 1'b1);

        // Single add, then ripple-carry corners.
        drive(1'b1, 1'b0, 16'h001D, 16'h0055, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Stream with a bubble after the second operand set.
        drive(1'b1, 1'b0, 16'h0069, 16'h000F, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 16'h0079, 16'h000F, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 16'h00E9, 16'h020F, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 16'h0479, 16'h020F, 1'b0, 1'b1, 1'b0);

        // Subtract cases.
        drive(1'b1, 1'b1, 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 16'h0010, 16'h0003, 1'b1, 1'b1, 1'b0);
        idle(20);

        // Stall with three results in flight; inputs during stall are junk.
        drive(1'b1, 1'b0, 16'h1111, 16'h2222, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 16'h3333, 16'h0444, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 16'hF0F0, 16'h0F10, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 16'hAAAA, 16'h5555, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 16'h5555, 16'hAAAA, 1'b0, 1'b0, 1'b0);
        idle(20);

        // Reset pulse with three results in flight.
        drive(1'b1, 1'b0, 16'h0101, 16'h0202, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 16'h0303, 16'h0404, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 16'h0505, 16'h0606, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 16'h0707, 16'h0808, 1'b0, 1'b1, 1'b1);
        idle(20);

        // Randomised traffic with stalls, bubbles and rare resets.
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
                  16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 99) == 0));
        end

        idle(20);
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) check({nm[k], "_drained"}, 32'(q[k].size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
Parametrised, carry-pipelined WIDTH-bit adder/subtractor that succeeds the fixed 16-bit pipelined adder. The operand is split into STAGES equal chunks. Each stage adds one chunk and registers its carry into the next stage. Operand skew and result de-skew registers keep one full result per cycle in flight. It adds a valid tag, a clock-enable stall, subtract mode and signed overflow. It sits in the datapath wherever a wide add must close timing at high clock rate.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be divisible by STAGES.
- STAGES, 4, number of pipeline stages (chunks); 1 <= STAGES <= WIDTH. CHUNK = WIDTH/STAGES.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- ce  input  1  clock enable; 0 freezes the entire pipeline.
- in_valid  input  1  operands valid this cycle.
- sub  input  1  0 = add, 1 = subtract.
- a  input  WIDTH  operand A (unsigned or two's complement).
- b  input  WIDTH  operand B.
- cin  input  1  carry-in when adding; borrow-in when subtracting.
- out_valid  output  1  sum/cout/overflow hold a result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out; in subtract mode 1 = no borrow.
- overflow  output  1  two's-complement overflow of the result.

Behaviour:
- Reset: on any rising edge with reset=1, all of the following clear to 0, regardless of ce:
  - stage valid bits
  - carry registers
  - skew and de-skew registers
  - out_valid, sum, cout, overflow
- Reset asserted mid-stream flushes every in-flight result; none emerges after reset.
- Effective operands: bx = b XOR {WIDTH{sub}}; c0 = cin XOR sub.
  - sub=1, cin=0 gives a-b.
  - sub=1, cin=1 gives a-b-1.
- Stage i (0..STAGES-1):
  - Adds chunk i of a and bx plus the carry registered by stage i-1 (stage 0 uses c0).
  - Registers the CHUNK-bit partial sum and the carry.
  - Higher chunks of a/bx, and the top sign bits needed for overflow, are delayed alongside.
  - Lower completed chunks are delayed to align at the output.
- Latency: operands presented in cycle 0 with in_valid=1 and ce=1 appear with out_valid=1 in cycle STAGES (STAGES register stages). STAGES=1 reduces to a single registered add.
- Throughput: one result per ce cycle. Back-to-back inputs produce back-to-back outputs, in order.
- in_valid=0: a bubble propagates. Data registers may still load, but out_valid=0 for that slot.
- ce=0 (and reset=0): no register changes; outputs hold their value; no input is sampled. Resuming ce loses and duplicates nothing.
- cout: carry out of bit WIDTH-1, i.e. of the full (WIDTH+1)-bit sum a + bx + c0.
- overflow: (a[W-1] == bx[W-1]) && (sum[W-1] != a[W-1]), evaluated with bx after inversion.
- Outputs are registered only; no combinational path from inputs to outputs.
- Operand and cin values are don't-care when in_valid=0; they must not affect the value of any later valid result.

Decomposition:
- No shared package needed. CHUNK is a local constant derived from WIDTH/STAGES; elaboration fails if WIDTH % STAGES != 0.
- One sub-module, adder_slice (parameter CHUNK):
  - Combinational CHUNK-bit add of x, y, ci giving s, co.
  - The parent instantiates it STAGES times in a generate loop and owns all registers, skew, valid and ce logic.

Test Plan (WIDTH=16, STAGES=4 unless noted):
- Reset: hold reset=1 for 3 cycles with in_valid=1 and ce=1 -> out_valid=0, sum=0x0000, cout=0, overflow=0 throughout.
- Single add: a=0x001D, b=0x0055, cin=0, sub=0 in cycle 0 -> cycle 4: out_valid=1, sum=0x0072, cout=0.
- Full carry ripple across all chunks:
  - a=0xFFFF, b=0x0001 -> sum=0x0000, cout=1, overflow=0.
  - a=0x7FFF, b=0x0001 -> sum=0x8000, overflow=1.
- Streaming: consecutive inputs 0x0069+0x000F, 0x0079+0x000F, 0x00E9+0x020F, 0x0479+0x020F, with a bubble inserted after the second -> outputs 0x0078, 0x0088, bubble, 0x02F8, 0x0688 in consecutive cycles, all cout=0.
- Subtract:
  - 0x0005-0x0007 -> 0xFFFE, cout=0.
  - 0x8000-0x0001 -> 0x7FFF, cout=1, overflow=1.
  - a=0x0010, b=0x0003, sub=1, cin=1 -> 0x000C.
- Stall and reset mid-stream:
  - ce=0 for 2 cycles while 3 results are in flight -> outputs frozen, then results resume in order with no loss.
  - reset pulse with 3 results in flight -> out_valid=0 from the next cycle and no stale result ever emerges.
  - Repeat the single add with STAGES=1 and STAGES=16 -> latency 1 and 16 respectively.
